// File: rtl/modclk_phase_sweeper.sv
// rtl/modclk_phase_sweeper.sv - phase/duty sweep sequencer for the 32-step modulation clock generator
module modclk_phase_sweeper (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic [4:0] PHASE_START,
  input  logic [4:0] PHASE_STEP,
  input  logic [4:0] NUM_STEPS,
  input  logic [7:0] PERIODS_PER_STEP,
  input  logic [3:0] DUTY_IN,
  output logic [4:0] PHASE_SEL,
  output logic [3:0] DUTY_SEL,
  output logic [4:0] STEP_IDX,
  output logic       STEP_STROBE,
  output logic       BUSY,
  output logic       DONE,
  output logic       PERIOD_SYNC
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_DWELL = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Free-running period counter mirroring the generator's down-counter.
  logic [4:0] pcnt_q;
  logic [4:0] pcnt_d;
  logic       boundary;

  // Periods completed at the current phase.
  logic [7:0] dcnt_q, dcnt_d;

  // Sweep configuration captured when a sweep is accepted.
  logic [4:0] cfg_start_q, cfg_start_d;
  logic [4:0] cfg_step_q, cfg_step_d;
  logic [4:0] cfg_nsteps_q, cfg_nsteps_d;
  logic [7:0] cfg_last_dwell_q, cfg_last_dwell_d;
  logic [3:0] cfg_duty_q, cfg_duty_d;

  // Registered outputs towards the clock generator.
  logic [4:0] phase_q, phase_d;
  logic [3:0] duty_q, duty_d;
  logic [4:0] idx_q, idx_d;
  logic       strobe_q, strobe_d;

  assign pcnt_d   = pcnt_q - 5'd1;
  assign boundary = (pcnt_q == 5'd0);

  // State register and all datapath registers; reset restores every one.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q          <= S_IDLE;
      pcnt_q           <= 5'd31;
      dcnt_q           <= 8'd0;
      cfg_start_q      <= 5'd0;
      cfg_step_q       <= 5'd0;
      cfg_nsteps_q     <= 5'd0;
      cfg_last_dwell_q <= 8'd0;
      cfg_duty_q       <= 4'd0;
      phase_q          <= 5'd0;
      duty_q           <= 4'd0;
      idx_q            <= 5'd0;
      strobe_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pcnt_q           <= pcnt_d;
      dcnt_q           <= dcnt_d;
      cfg_start_q      <= cfg_start_d;
      cfg_step_q       <= cfg_step_d;
      cfg_nsteps_q     <= cfg_nsteps_d;
      cfg_last_dwell_q <= cfg_last_dwell_d;
      cfg_duty_q       <= cfg_duty_d;
      phase_q          <= phase_d;
      duty_q           <= duty_d;
      idx_q            <= idx_d;
      strobe_q         <= strobe_d;
    end
  end

  // Next-state logic; STOP outranks any boundary update so an abort never changes outputs.
  always_comb begin
    state_d          = state_q;
    dcnt_d           = dcnt_q;
    cfg_start_d      = cfg_start_q;
    cfg_step_d       = cfg_step_q;
    cfg_nsteps_d     = cfg_nsteps_q;
    cfg_last_dwell_d = cfg_last_dwell_q;
    cfg_duty_d       = cfg_duty_q;
    phase_d          = phase_q;
    duty_d           = duty_q;
    idx_d            = idx_q;
    strobe_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          cfg_start_d  = PHASE_START;
          cfg_step_d   = PHASE_STEP;
          cfg_nsteps_d = NUM_STEPS;
          cfg_duty_d   = DUTY_IN;
          // A dwell of zero periods would be meaningless, so it behaves as one.
          cfg_last_dwell_d = (PERIODS_PER_STEP == 8'd0) ? 8'd0 : (PERIODS_PER_STEP - 8'd1);
          state_d      = S_ARM;
        end
      end

      S_ARM: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (boundary) begin
          phase_d  = cfg_start_q;
          duty_d   = cfg_duty_q;
          idx_d    = 5'd0;
          dcnt_d   = 8'd0;
          strobe_d = 1'b1;
          state_d  = S_DWELL;
        end
      end

      S_DWELL: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (boundary) begin
          if (dcnt_q != cfg_last_dwell_q) begin
            dcnt_d = dcnt_q + 8'd1;
          end else if (idx_q != cfg_nsteps_q) begin
            dcnt_d   = 8'd0;
            idx_d    = idx_q + 5'd1;
            phase_d  = phase_q + cfg_step_q;
            strobe_d = 1'b1;
          end else begin
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PHASE_SEL   = phase_q;
  assign DUTY_SEL    = duty_q;
  assign STEP_IDX    = idx_q;
  assign STEP_STROBE = strobe_q;
  assign BUSY        = (state_q == S_ARM) || (state_q == S_DWELL);
  assign DONE        = (state_q == S_FIN);
  assign PERIOD_SYNC = boundary;

endmodule

// File: tb/tb_modclk_phase_sweeper.sv
// tb/tb_modclk_phase_sweeper.sv - scoreboard bench for modclk_phase_sweeper
module tb_modclk_phase_sweeper;

  logic       clk;
  logic       RST;
  logic       START;
  logic       STOP;
  logic [4:0] PHASE_START;
  logic [4:0] PHASE_STEP;
  logic [4:0] NUM_STEPS;
  logic [7:0] PERIODS_PER_STEP;
  logic [3:0] DUTY_IN;
  logic [4:0] PHASE_SEL;
  logic [3:0] DUTY_SEL;
  logic [4:0] STEP_IDX;
  logic       STEP_STROBE;
  logic       BUSY;
  logic       DONE;
  logic       PERIOD_SYNC;

  modclk_phase_sweeper dut (
    .CLK_IN          (clk),
    .RST             (RST),
    .START           (START),
    .STOP            (STOP),
    .PHASE_START     (PHASE_START),
    .PHASE_STEP      (PHASE_STEP),
    .NUM_STEPS       (NUM_STEPS),
    .PERIODS_PER_STEP(PERIODS_PER_STEP),
    .DUTY_IN         (DUTY_IN),
    .PHASE_SEL       (PHASE_SEL),
    .DUTY_SEL        (DUTY_SEL),
    .STEP_IDX        (STEP_IDX),
    .STEP_STROBE     (STEP_STROBE),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .PERIOD_SYNC     (PERIOD_SYNC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last edge that sampled RST high.
  int cyc;
  always @(posedge clk) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_checks;
  int n_pass;

  typedef struct {
    bit is_done;
    int cyc;
    int phase;
    int duty;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
  endtask

  task automatic push_ev(input bit is_done, input int c, input int ph, input int du, input int ix);
    ev_t x;
    x.is_done = is_done;
    x.cyc     = c;
    x.phase   = ph;
    x.duty    = du;
    x.idx     = ix;
    exp_q.push_back(x);
  endtask

  // Monitor: every strobe or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (!RST && (STEP_STROBE || DONE)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d strobe=%0b done=%0b phase=%0d", cyc, STEP_STROBE, DONE, PHASE_SEL);
      end else begin
        e = exp_q.pop_front();
        if (DONE == e.is_done && STEP_STROBE == !e.is_done && cyc == e.cyc &&
            int'(PHASE_SEL) == e.phase && int'(DUTY_SEL) == e.duty && int'(STEP_IDX) == e.idx) begin
          n_pass++;
        end else begin
          $display("FAIL event actual: cyc=%0d done=%0b strobe=%0b phase=%0d duty=%0d idx=%0d expected: cyc=%0d done=%0b phase=%0d duty=%0d idx=%0d",
                   cyc, DONE, STEP_STROBE, PHASE_SEL, DUTY_SEL, STEP_IDX,
                   e.cyc, e.is_done, e.phase, e.duty, e.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    RST   = 1'b1;
    START = 1'b0;
    STOP  = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic drive_cfg(input int ps, input int st, input int ns, input int pps, input int du);
    PHASE_START      = 5'(ps);
    PHASE_STEP       = 5'(st);
    NUM_STEPS        = 5'(ns);
    PERIODS_PER_STEP = 8'(pps);
    DUTY_IN          = 4'(du);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"}, int'(PHASE_SEL), 0);
    check({tag, "_duty"}, int'(DUTY_SEL), 0);
    check({tag, "_idx"}, int'(STEP_IDX), 0);
    check({tag, "_strobe"}, int'(STEP_STROBE), 0);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_done"}, int'(DONE), 0);
    check({tag, "_psync"}, int'(PERIOD_SYNC), 0);
  endtask

  int exp_phase;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST      = 1'b1;
    START    = 1'b0;
    STOP     = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);

    // Reset values, then the basic sweep start=4 step=3 steps=2 pps=2 duty=5.
    do_reset();
    check_reset_values("rst");
    push_ev(0, 32, 4, 5, 0);
    push_ev(0, 96, 7, 5, 1);
    push_ev(0, 160, 10, 5, 2);
    push_ev(1, 224, 10, 5, 2);
    while (cyc < 230) begin
      @(negedge clk);
      if (cyc == 1) begin drive_cfg(4, 3, 2, 2, 5); START = 1'b1; end
      else START = 1'b0;
      check("basic_busy", int'(BUSY), int'(cyc >= 2 && cyc <= 223));
      check("basic_psync", int'(PERIOD_SYNC), int'(cyc % 32 == 31));
      exp_phase = (cyc < 32) ? 0 : (cyc < 96) ? 4 : (cyc < 160) ? 7 : 10;
      check("basic_phase", int'(PHASE_SEL), exp_phase);
    end

    // Wrap with PPS=0, plus a START while busy carrying a different configuration.
    do_reset();
    push_ev(0, 32, 30, 9, 0);
    push_ev(0, 64, 1, 9, 1);
    push_ev(1, 96, 1, 9, 1);
    while (cyc < 110) begin
      @(negedge clk);
      if (cyc == 1) begin drive_cfg(30, 3, 1, 0, 9); START = 1'b1; end
      else if (cyc == 40) begin drive_cfg(0, 1, 31, 5, 2); START = 1'b1; end
      else START = 1'b0;
      check("wrap_busy", int'(BUSY), int'(cyc >= 2 && cyc <= 95));
      exp_phase = (cyc < 32) ? 0 : (cyc < 64) ? 30 : 1;
      check("wrap_phase", int'(PHASE_SEL), exp_phase);
    end

    // Abort in the second phase of the basic sweep, then a fresh one-phase sweep.
    do_reset();
    push_ev(0, 32, 4, 5, 0);
    push_ev(0, 96, 7, 5, 1);
    push_ev(0, 256, 1, 3, 0);
    push_ev(1, 288, 1, 3, 0);
    while (cyc < 300) begin
      @(negedge clk);
      if (cyc == 1) begin drive_cfg(4, 3, 2, 2, 5); START = 1'b1; end
      else if (cyc == 250) begin drive_cfg(1, 2, 0, 1, 3); START = 1'b1; end
      else START = 1'b0;
      STOP = (cyc == 100);
      check("abort_busy", int'(BUSY), int'((cyc >= 2 && cyc <= 100) || (cyc >= 251 && cyc <= 287)));
      exp_phase = (cyc < 32) ? 0 : (cyc < 96) ? 4 : (cyc < 256) ? 7 : 1;
      check("abort_phase", int'(PHASE_SEL), exp_phase);
    end

    // START and STOP together in IDLE must not arm a sweep.
    do_reset();
    while (cyc < 70) begin
      @(negedge clk);
      if (cyc == 1) begin drive_cfg(6, 1, 0, 1, 7); START = 1'b1; STOP = 1'b1; end
      else begin START = 1'b0; STOP = 1'b0; end
      check("contend_busy", int'(BUSY), 0);
      check("contend_phase", int'(PHASE_SEL), 0);
    end

    // Reset at cycle 100 of the basic sweep.
    do_reset();
    push_ev(0, 32, 4, 5, 0);
    push_ev(0, 96, 7, 5, 1);
    while (cyc < 100) begin
      @(negedge clk);
      if (cyc == 1) begin drive_cfg(4, 3, 2, 2, 5); START = 1'b1; end
      else START = 1'b0;
    end
    check("pre_rst_busy", int'(BUSY), 1);
    check("pre_rst_phase", int'(PHASE_SEL), 7);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check_reset_values("midrst");
    while (cyc < 70) begin
      @(negedge clk);
      check("midrst_psync", int'(PERIOD_SYNC), int'(cyc % 32 == 31));
      check("midrst_busy", int'(BUSY), 0);
    end

    check("events_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
